rename_stage: RTL and testbench
===============================

# rename_stage

- Register-rename stage of the out-of-order RISC-V pipeline. Sits between decode and dispatch, directly downstream of the physical-register freelist.
- Per instruction:
  - maps architectural rs1/rs2/rd to physical registers;
  - pops a new destination from the freelist;
  - reports the previous mapping of rd so it can be freed at commit.
- Owns the speculative map table, the freelist occupancy count, and ROB-driven walk-back recovery after a flush.

## Interface
Parameters:
- AREG_W, 5, architectural register index width (32 regs)
- PREG_W, 6, physical register index width
- FL_SIZE, 32, freelist capacity; the freelist is built with STNUM = 2**AREG_W

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - i_clk  in  1  clock
  - i_rst  in  1  synchronous reset, active-high
- Upstream (decode):
  - i_valid  in  1  decode offers an instruction
  - o_ready  out  1  stage accepts this cycle
  - i_rs1, i_rs2, i_rd  in  AREG_W each  architectural indices
  - i_rd_we  in  1  instruction writes rd
- Downstream (dispatch):
  - o_valid  out  1  renamed instruction held
  - i_ready  in  1  dispatch takes it
  - o_prs1, o_prs2, o_prd, o_oldprd  out  PREG_W each  physical indices
  - o_rd_en  out  1  destination allocated
- Freelist:
  - o_fl_re  out  1  pop freelist
  - i_fl_data  in  PREG_W  freelist head
  - o_fl_we  out  1  push freelist
  - o_fl_wdata  out  PREG_W  register returned
- Commit (ROB):
  - i_cmt_valid  in  1  instruction retires
  - i_cmt_oldprd  in  PREG_W  previous mapping to free
  - i_cmt_rd_en  in  1  retiring instruction had a destination
- Recovery (ROB):
  - i_flush  in  1  one-cycle pulse
  - i_sq_valid  in  1  squashed entry presented
  - i_sq_rd  in  AREG_W  squashed entry's rd
  - i_sq_prd, i_sq_oldprd  in  PREG_W each  squashed entry's physical indices
  - i_sq_done  in  1  last squash cycle

## Operation
- **Reset values:**
  - map[i] = i; state RUN; free count = FL_SIZE.
  - o_valid = 0; o_fl_re = 0; o_fl_we = 0; o_rd_en = 0; all index outputs 0.
- **rd_en:** rd_en = i_rd_we & (i_rd != 0). x0 is never renamed, and map[0] stays 0 permanently.
- **o_ready** = (state == RUN) & !i_flush & (!o_valid | i_ready) & (count != 0 | !rd_en).
- **Accept** = i_valid & o_ready. On accept:
  - Output register loads:
    - o_prs1 = map[rs1]
    - o_prs2 = map[rs2]
    - o_oldprd = map[rd]
    - o_prd = rd_en ? i_fl_data : 0
    - o_rd_en = rd_en
  - map[rd] <= i_fl_data when rd_en.
  - o_fl_re = rd_en, combinationally in the same cycle.
- **Source equals destination:** when rs equals rd in the same instruction, the rs read returns the pre-update mapping.
- **Output register:** o_valid clears on i_ready when no accept happens in that cycle.
- **Commit:** i_cmt_valid & i_cmt_rd_en drives o_fl_we = 1 and o_fl_wdata = i_cmt_oldprd, and increments count.
- **Count update:** count changes by (+1 per push) − (1 per pop). Simultaneous pop and push leaves count unchanged.
- **State RUN → RECOVER** on i_flush. In the flush cycle:
  - o_valid <= 0.
  - If o_valid & o_rd_en: map[rd of held instr] <= o_oldprd, and o_prd is pushed to the freelist (count + 1). The stage keeps the held instruction's rd internally for this.
- **RECOVER:**
  - o_ready = 0.
  - Each i_sq_valid with i_sq_rd != 0: map[i_sq_rd] <= i_sq_oldprd, push i_sq_prd, count + 1.
  - The ROB presents entries youngest-first.
  - i_sq_done → RUN next cycle. An entry valid in the i_sq_done cycle is still processed.
- **ROB guarantees** (bench asserts): i_cmt_valid = 0 in the flush cycle and during RECOVER.
- **Count overflow** (count > FL_SIZE) is an assertion failure.

## Timing
- Rename latency: 1 cycle, accept edge → o_valid.
- Back-to-back dependent instructions see the updated map with no bubble.
- A freelist push is allocatable from the next cycle.
- A mid-operation reset overrides everything in the same edge: map, count, state and the output register return to reset values.

## Structure
- Package rename_pkg holds:
  - AREG_W/PREG_W/FL_SIZE defaults;
  - state enum {RUN, RECOVER};
  - the renamed-instruction struct (prs1, prs2, prd, oldprd, rd_en).
- Sub-module map_table:
  - 2**AREG_W × PREG_W storage, reset to identity, entry 0 hardwired to 0;
  - 3 combinational read ports;
  - 1 write port, since rename writes and recovery writes are mutually exclusive.

## Test plan
- **Basic rename after reset:** rd=5, rs1=5, rs2=0, i_fl_data=32 → o_prs1=5, o_prs2=0, o_prd=32, o_oldprd=5, o_fl_re pulse, count=31.
- **Back-to-back dependency:** second instruction rs1=5 the next cycle → o_prs1=32, no stall cycle.
- **Exhaustion:**
  - 32 allocations without commits → count=0 and o_ready=0 for rd=3.
  - A rd=0 instruction is still accepted.
  - Commit oldprd=5 → o_fl_we with wdata=5, and o_ready=1 the next cycle.
- **Downstream stall:** i_ready=0 for 3 cycles → outputs stable, o_ready=0, exactly one o_fl_re.
- **Flush with held instruction** (rd=7, prd=40, oldprd=7):
  - Flush cycle → o_fl_wdata=40, map[7]=7, o_valid=0.
  - Squash entry (rd=5, prd=33, oldprd=32) → map[5]=32.
  - i_sq_done → RUN, count restored.
- **Reset during RECOVER:** i_rst → next cycle state RUN, identity map, count=32, o_valid=0.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared widths and types for the register-rename stage.
package rename_pkg;

    localparam int unsigned AREG_W_DFLT  = 5;
    localparam int unsigned PREG_W_DFLT  = 6;
    localparam int unsigned FL_SIZE_DFLT = 32;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

    // Payload held in the output register towards dispatch.
    typedef struct packed {
        logic [PREG_W_DFLT-1:0] prs1;
        logic [PREG_W_DFLT-1:0] prs2;
        logic [PREG_W_DFLT-1:0] prd;
        logic [PREG_W_DFLT-1:0] oldprd;
        logic                   rd_en;
    } renamed_t;

endpackage

// File: rtl/rename_map_table.sv
// Speculative architectural-to-physical map: identity after reset, x0 pinned to p0.
module map_table
    import rename_pkg::*;
#(
    parameter int unsigned AREG_W = AREG_W_DFLT,
    parameter int unsigned PREG_W = PREG_W_DFLT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AREG_W-1:0] raddr0_i,
    input  logic [AREG_W-1:0] raddr1_i,
    input  logic [AREG_W-1:0] raddr2_i,
    output logic [PREG_W-1:0] rdata0_c_o,
    output logic [PREG_W-1:0] rdata1_c_o,
    output logic [PREG_W-1:0] rdata2_c_o,
    input  logic              we_i,
    input  logic [AREG_W-1:0] waddr_i,
    input  logic [PREG_W-1:0] wdata_i
);

    localparam int unsigned NREG = 1 << AREG_W;

    logic [PREG_W-1:0] map_q [NREG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                map_q[i] <= PREG_W'(i);
            end
        end else if (we_i && (waddr_i != '0)) begin
            map_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-update contents, so rs == rd returns the old mapping.
    assign rdata0_c_o = (raddr0_i == '0) ? '0 : map_q[raddr0_i];
    assign rdata1_c_o = (raddr1_i == '0) ? '0 : map_q[raddr1_i];
    assign rdata2_c_o = (raddr2_i == '0) ? '0 : map_q[raddr2_i];

endmodule

// File: rtl/rename_stage.sv
// Rename stage: maps sources/destination through the speculative map, allocates
// from the freelist, and walks the map back from squashed ROB entries after a flush.
module rename_stage
    import rename_pkg::*;
#(
    parameter int unsigned AREG_W  = AREG_W_DFLT,
    parameter int unsigned PREG_W  = PREG_W_DFLT,
    parameter int unsigned FL_SIZE = FL_SIZE_DFLT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [AREG_W-1:0] i_rs1,
    input  logic [AREG_W-1:0] i_rs2,
    input  logic [AREG_W-1:0] i_rd,
    input  logic              i_rd_we,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [PREG_W-1:0] o_prs1,
    output logic [PREG_W-1:0] o_prs2,
    output logic [PREG_W-1:0] o_prd,
    output logic [PREG_W-1:0] o_oldprd,
    output logic              o_rd_en,
    output logic              o_fl_re,
    input  logic [PREG_W-1:0] i_fl_data,
    output logic              o_fl_we,
    output logic [PREG_W-1:0] o_fl_wdata,
    input  logic              i_cmt_valid,
    input  logic [PREG_W-1:0] i_cmt_oldprd,
    input  logic              i_cmt_rd_en,
    input  logic              i_flush,
    input  logic              i_sq_valid,
    input  logic [AREG_W-1:0] i_sq_rd,
    input  logic [PREG_W-1:0] i_sq_prd,
    input  logic [PREG_W-1:0] i_sq_oldprd,
    input  logic              i_sq_done
);

    localparam int unsigned CNT_W = $clog2(FL_SIZE + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    renamed_t          out_q, out_d;
    logic [AREG_W-1:0] held_rd_q, held_rd_d;

    logic              rd_en_c, ready_c, accept_c, pop_c;
    logic              undo_c, sq_push_c, cmt_push_c, push_c;
    logic [PREG_W-1:0] push_data_c;
    logic              map_we_c;
    logic [AREG_W-1:0] map_waddr_c;
    logic [PREG_W-1:0] map_wdata_c;
    logic [PREG_W-1:0] map_prs1_c, map_prs2_c, map_old_c;

    map_table #(
        .AREG_W (AREG_W),
        .PREG_W (PREG_W)
    ) u_map (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .raddr0_i   (i_rs1),
        .raddr1_i   (i_rs2),
        .raddr2_i   (i_rd),
        .rdata0_c_o (map_prs1_c),
        .rdata1_c_o (map_prs2_c),
        .rdata2_c_o (map_old_c),
        .we_i       (map_we_c),
        .waddr_i    (map_waddr_c),
        .wdata_i    (map_wdata_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (i_flush)   state_d = RECOVER;
            RECOVER: if (i_sq_done) state_d = RUN;
        endcase
    end

    // Per-state handshake and freelist-return sources.
    always_comb begin
        rd_en_c    = i_rd_we & (i_rd != '0);
        ready_c    = 1'b0;
        undo_c     = 1'b0;
        sq_push_c  = 1'b0;
        cmt_push_c = 1'b0;
        case (state_q)
            RUN: begin
                ready_c    = ~i_rst & ~i_flush & (~valid_q | i_ready)
                           & ((cnt_q != '0) | ~rd_en_c);
                undo_c     = ~i_rst & i_flush & valid_q & out_q.rd_en;
                cmt_push_c = ~i_rst & ~i_flush & i_cmt_valid & i_cmt_rd_en;
            end
            RECOVER: begin
                sq_push_c  = ~i_rst & i_sq_valid & (i_sq_rd != '0);
            end
        endcase
    end

    assign accept_c = i_valid & ready_c;
    assign pop_c    = accept_c & rd_en_c;
    assign push_c   = undo_c | sq_push_c | cmt_push_c;

    // Rename, flush-undo and squash writes never coincide, so one port suffices.
    always_comb begin
        push_data_c = '0;
        map_we_c    = pop_c | undo_c | sq_push_c;
        map_waddr_c = i_sq_rd;
        map_wdata_c = i_sq_oldprd;
        if (undo_c) begin
            push_data_c = out_q.prd;
            map_waddr_c = held_rd_q;
            map_wdata_c = out_q.oldprd;
        end else if (sq_push_c) begin
            push_data_c = i_sq_prd;
        end else if (cmt_push_c) begin
            push_data_c = i_cmt_oldprd;
        end
        if (pop_c) begin
            map_waddr_c = i_rd;
            map_wdata_c = i_fl_data;
        end
    end

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        valid_d   = valid_q;
        out_d     = out_q;
        held_rd_d = held_rd_q;
        if (accept_c) begin
            valid_d      = 1'b1;
            out_d.prs1   = map_prs1_c;
            out_d.prs2   = map_prs2_c;
            out_d.oldprd = map_old_c;
            out_d.prd    = rd_en_c ? i_fl_data : '0;
            out_d.rd_en  = rd_en_c;
            held_rd_d    = i_rd;
        end else if (i_flush || i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= CNT_W'(FL_SIZE);
            valid_q   <= 1'b0;
            out_q     <= '0;
            held_rd_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            out_q     <= out_d;
            held_rd_q <= held_rd_d;
        end
    end

    // More returns than allocations means the ROB handed back a register twice.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (cnt_d <= CNT_W'(FL_SIZE));
        end
    end

    assign o_ready    = ready_c;
    assign o_fl_re    = pop_c;
    assign o_fl_we    = push_c;
    assign o_fl_wdata = push_data_c;
    assign o_valid    = valid_q;
    assign o_prs1     = out_q.prs1;
    assign o_prs2     = out_q.prs2;
    assign o_prd      = out_q.prd;
    assign o_oldprd   = out_q.oldprd;
    assign o_rd_en    = out_q.rd_en;

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: environment freelist/ROB queues plus a behavioural rename model.
module tb_rename_stage;

    localparam int unsigned AW   = 5;
    localparam int unsigned PW   = 6;
    localparam int unsigned FS   = 32;
    localparam int unsigned NREG = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid, rd_we, dn_ready, cmt_valid, cmt_rd_en, flush, sq_valid, sq_done;
    logic [AW-1:0] rs1, rs2, rd, sq_rd;
    logic [PW-1:0] fl_data, cmt_oldprd, sq_prd, sq_oldprd;
    logic          o_ready, o_valid, o_rd_en, o_fl_re, o_fl_we;
    logic [PW-1:0] o_prs1, o_prs2, o_prd, o_oldprd, o_fl_wdata;

    rename_stage dut (
        .i_clk(clk), .i_rst(rst),
        .i_valid(valid), .o_ready(o_ready),
        .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_rd_we(rd_we),
        .o_valid(o_valid), .i_ready(dn_ready),
        .o_prs1(o_prs1), .o_prs2(o_prs2), .o_prd(o_prd), .o_oldprd(o_oldprd), .o_rd_en(o_rd_en),
        .o_fl_re(o_fl_re), .i_fl_data(fl_data),
        .o_fl_we(o_fl_we), .o_fl_wdata(o_fl_wdata),
        .i_cmt_valid(cmt_valid), .i_cmt_oldprd(cmt_oldprd), .i_cmt_rd_en(cmt_rd_en),
        .i_flush(flush), .i_sq_valid(sq_valid), .i_sq_rd(sq_rd),
        .i_sq_prd(sq_prd), .i_sq_oldprd(sq_oldprd), .i_sq_done(sq_done)
    );

    typedef struct {
        int rd;
        int prd;
        int old;
        bit rden;
    } rob_t;

    // Environment: the physical freelist and the in-flight ROB.
    int   fl_q[$];
    rob_t rob[$];

    // Model of the stage's architectural view.
    int m_map [NREG];
    bit m_rec;
    bit m_ov;
    int m_prs1, m_prs2, m_prd, m_old, m_hrd;
    bit m_rden;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit s_ready, s_fl_re, s_fl_we;
    int s_fl_wdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_map[i] = i;
        m_rec = 0; m_ov = 0; m_rden = 0;
        m_prs1 = 0; m_prs2 = 0; m_prd = 0; m_old = 0; m_hrd = 0;
        fl_q.delete();
        for (int i = 0; i < FS; i++) fl_q.push_back(32 + i);
        rob.delete();
    endtask

    task automatic idle_inputs();
        rst = 0; valid = 0; rs1 = '0; rs2 = '0; rd = '0; rd_we = 0; dn_ready = 1;
        cmt_valid = 0; cmt_rd_en = 0; cmt_oldprd = '0; flush = 0;
        sq_valid = 0; sq_rd = '0; sq_prd = '0; sq_oldprd = '0; sq_done = 0;
    endtask

    // Inputs are already driven (after negedge); compare, then advance the model.
    task automatic cycle();
        bit e_rden, e_rdy, e_acc, e_pop, e_we, undo;
        int e_wd, fd;
        fl_data = (fl_q.size() != 0) ? PW'(fl_q[0]) : '0;
        fd = int'(fl_data);
        #1;
        e_rden = rd_we && (rd != 0);
        e_rdy  = !rst && !m_rec && !flush && (!m_ov || dn_ready) && (fl_q.size() != 0 || !e_rden);
        e_acc  = valid && e_rdy;
        e_pop  = e_acc && e_rden;
        undo   = !rst && !m_rec && flush && m_ov && m_rden;
        e_we = 0; e_wd = 0;
        if (undo) begin
            e_we = 1; e_wd = m_prd;
        end else if (!rst && m_rec && sq_valid && sq_rd != 0) begin
            e_we = 1; e_wd = int'(sq_prd);
        end else if (!rst && !m_rec && !flush && cmt_valid && cmt_rd_en) begin
            e_we = 1; e_wd = int'(cmt_oldprd);
        end
        assert (!(cmt_valid && (flush || m_rec)));

        s_ready = o_ready; s_fl_re = o_fl_re; s_fl_we = o_fl_we; s_fl_wdata = int'(o_fl_wdata);
        if (chk_en) begin
            check("ready",    o_ready,    e_rdy);
            check("fl_re",    o_fl_re,    e_pop);
            check("fl_we",    o_fl_we,    e_we);
            check("fl_wdata", o_fl_wdata, e_wd);
            check("valid",    o_valid,    m_ov);
            check("prs1",     o_prs1,     m_prs1);
            check("prs2",     o_prs2,     m_prs2);
            check("prd",      o_prd,      m_prd);
            check("oldprd",   o_oldprd,   m_old);
            check("rd_en",    o_rd_en,    m_rden);
        end

        if (rst) begin
            model_reset();
        end else begin
            if (!m_rec && !flush && m_ov && dn_ready)
                rob.push_back('{m_hrd, m_prd, m_old, m_rden});
            if (undo) m_map[m_hrd] = m_old;
            if (m_rec && sq_valid && sq_rd != 0) m_map[sq_rd] = int'(sq_oldprd);
            if (e_acc) begin
                m_prs1 = m_map[rs1]; m_prs2 = m_map[rs2]; m_old = m_map[rd];
                m_prd  = e_rden ? fd : 0;
                m_rden = e_rden; m_hrd = int'(rd); m_ov = 1;
            end else if (flush || dn_ready) begin
                m_ov = 0;
            end
            if (e_pop) begin
                m_map[rd] = fd;
                void'(fl_q.pop_front());
            end
            if (e_we) fl_q.push_back(e_wd);
            assert (fl_q.size() <= FS);
            if (!m_rec && flush) m_rec = 1;
            else if (m_rec && sq_done) m_rec = 0;
        end
    endtask

    task automatic ins(input int r1, input int r2, input int d, input bit we, input bit dr);
        @(negedge clk);
        idle_inputs();
        valid = 1; rs1 = AW'(r1); rs2 = AW'(r2); rd = AW'(d); rd_we = we; dn_ready = dr;
        cycle();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle_inputs();
            rst = 1;
            cycle();
            chk_en = 1;
        end
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic squash_all();
        rob_t e;
        while (rob.size() != 0) begin
            @(negedge clk);
            idle_inputs();
            e = rob.pop_back();
            sq_valid = 1; sq_rd = e.rden ? AW'(e.rd) : '0;
            sq_prd = PW'(e.prd); sq_oldprd = PW'(e.old);
            sq_done = (rob.size() == 0);
            cycle();
            check("sq_push", s_fl_we, e.rden);
        end
    endtask

    task automatic rand_cycle();
        rob_t e;
        @(negedge clk);
        idle_inputs();
        rst      = ($urandom_range(0, 499) == 0);
        valid    = ($urandom_range(0, 9) < 7);
        rs1      = AW'($urandom);
        rs2      = AW'($urandom);
        rd       = AW'($urandom);
        rd_we    = ($urandom_range(0, 9) < 8);
        dn_ready = ($urandom_range(0, 9) < 7);
        if (!rst && !m_rec) begin
            flush = ($urandom_range(0, 39) == 0);
            if (!flush && rob.size() != 0 && $urandom_range(0, 9) < 3) begin
                e = rob.pop_front();
                cmt_valid = 1; cmt_rd_en = e.rden; cmt_oldprd = PW'(e.old);
            end
        end else if (!rst) begin
            if (rob.size() == 0) begin
                sq_done = 1;
            end else if ($urandom_range(0, 9) < 7) begin
                e = rob.pop_back();
                sq_valid = 1; sq_rd = e.rden ? AW'(e.rd) : '0;
                sq_prd = PW'(e.prd); sq_oldprd = PW'(e.old);
                sq_done = (rob.size() == 0);
            end
        end
        cycle();
    endtask

    initial begin
        int fl_re_cnt;
        idle_inputs();
        fl_data = '0;
        model_reset();
        do_reset(2);
        post();
        check("rst_valid", o_valid, 0);
        check("rst_prd",   o_prd,   0);
        check("rst_rd_en", o_rd_en, 0);

        // Basic rename and back-to-back dependency.
        ins(5, 0, 5, 1, 1);
        check("t1_fl_re", s_fl_re, 1);
        post();
        check("t1_prs1", o_prs1, 5);
        check("t1_prs2", o_prs2, 0);
        check("t1_prd",  o_prd, 32);
        check("t1_old",  o_oldprd, 5);
        ins(5, 0, 6, 1, 1);
        check("t2_nostall", s_ready, 1);
        post();
        check("t2_prs1", o_prs1, 32);

        // Downstream stall: one allocation, then held stable.
        ins(0, 0, 10, 1, 1);
        fl_re_cnt = int'(s_fl_re);
        for (int i = 0; i < 3; i++) begin
            ins(1, 1, 11, 1, 0);
            fl_re_cnt += int'(s_fl_re);
            check("stall_ready", s_ready, 0);
            post();
            check("stall_prd", o_prd, 34);
        end
        check("stall_one_pop", fl_re_cnt, 1);
        ins(1, 1, 11, 1, 1);

        // Exhaustion, x0 pass-through, commit refill.
        for (int i = 0; i < 28; i++) ins(1, 2, 12 + (i % 15), 1, 1);
        ins(1, 2, 3, 1, 1);
        check("empty_block", s_ready, 0);
        ins(1, 2, 0, 1, 1);
        check("empty_x0", s_ready, 1);
        @(negedge clk);
        idle_inputs();
        begin
            rob_t e;
            e = rob.pop_front();
            cmt_valid = 1; cmt_rd_en = e.rden; cmt_oldprd = PW'(e.old);
        end
        valid = 1; rd = AW'(3); rd_we = 1;
        cycle();
        check("cmt_we", s_fl_we, 1);
        check("cmt_wdata", s_fl_wdata, 5);
        check("cmt_same_cycle", s_ready, 0);
        ins(0, 0, 3, 1, 1);
        check("refill_ready", s_ready, 1);
        post();
        check("refill_prd", o_prd, 5);

        // Flush with a held instruction, then youngest-first walk-back.
        do_reset(2);
        ins(0, 0, 5, 1, 1);
        ins(0, 0, 5, 1, 1);
        for (int i = 0; i < 6; i++) ins(0, 0, 10 + i, 1, 1);
        ins(0, 0, 7, 1, 1);
        @(negedge clk);
        idle_inputs();
        dn_ready = 0; flush = 1;
        cycle();
        check("flush_we", s_fl_we, 1);
        check("flush_wdata", s_fl_wdata, 40);
        post();
        check("flush_valid", o_valid, 0);
        squash_all();
        ins(7, 5, 0, 0, 1);
        check("rec_ready", s_ready, 1);
        post();
        check("rec_map7", o_prs1, 7);
        check("rec_map5", o_prs2, 5);

        // Reset in the middle of recovery.
        ins(0, 0, 7, 1, 1);
        ins(0, 0, 9, 1, 1);
        @(negedge clk);
        idle_inputs();
        dn_ready = 0; flush = 1;
        cycle();
        @(negedge clk);
        idle_inputs();
        cycle();
        check("in_recover", s_ready, 0);
        do_reset(1);
        post();
        check("rr_valid", o_valid, 0);
        ins(7, 9, 4, 1, 1);
        check("rr_ready", s_ready, 1);
        post();
        check("rr_prs1", o_prs1, 7);
        check("rr_prs2", o_prs2, 9);
        check("rr_prd",  o_prd, 32);

        for (int i = 0; i < 4000; i++) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
